cdc_hs_tx: RTL and testbench
============================

# cdc_hs_tx

Source-domain sender for the four-phase rdy/ack clock-domain-crossing handshake. It accepts a data word from local logic over valid/ready and holds it stable on the cross-domain data lines. It raises `rdy_o` toward the rdy synchronizer and walks the four-phase protocol against the already-synchronized `ack_i` returned from the destination domain. It sits directly upstream of the destination-side capture muxes and the rdy/ack synchronizer pair.

## Interface
Parameters:
- `DW`, 2, width of transferred word (one bit per crossing lane).
- `TIMEOUT_CYC`, 255, cycles spent in one handshake phase before abort; only used with the timeout feature; must be ≥ 4.

Ports:
- `ck`  in  1  source-domain clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_data`  in  DW  word to send.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `hold_data`  out  DW  registered word driven to the destination capture lanes.
- `rdy_o`  out  1  request level, registered, to the rdy synchronizer.
- `ack_i`  in  1  acknowledge, already synchronized into `ck` by an external 2FF; no internal synchronizer.
- `busy`  out  1  handshake in progress (state ≠ IDLE).
- `done`  out  1  one-cycle pulse when a transfer fully completes.
- `err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `err` and releases ERR state.

## Operation
The FSM has the states IDLE, REQ, REL and ERR. ERR exists only with the timeout feature.

- **IDLE:**
  - `in_ready = !ack_i`, combinational. A stale ack blocks acceptance.
  - On `in_valid && in_ready`: load `hold_data <= in_data` and go to REQ.
- **REQ:**
  - `rdy_o = 1`.
  - On `ack_i == 1`: go to REL.
- **REL:**
  - `rdy_o = 0`.
  - On `ack_i == 0`: go to IDLE and pulse `done` for the cycle after that edge.
- **ERR:**
  - `rdy_o = 0`, `in_ready = 0`, `err = 1`.
  - On `err_clr && !ack_i`: go to IDLE.
- **Data stability:** `hold_data` changes only on an accepting edge. It is stable for the whole of REQ and REL.
- **Output encoding:** `rdy_o` is a flop output, decoded as next-state == REQ, so it is glitch-free across the domain boundary.
- **Ack outside REQ/REL:** `ack_i` changes in IDLE or ERR have no effect other than gating `in_ready`.

## Timing
- **Reset values:** after the reset edge, state IDLE, `rdy_o=0`, `hold_data=0`, `busy=0`, `done=0`, `err=0`. `in_ready` follows `!ack_i`.
- **Reset mid-transfer:** returns to IDLE in one cycle and drops `rdy_o` immediately. The destination sees the request withdrawn; this is a permitted abort.
- **Accept to request:** accept at edge N; `hold_data` and `rdy_o=1` are visible after edge N, same edge.
- **Ack to release:** `ack_i=1` sampled at edge M; `rdy_o=0` after edge M.
- **Completion:** `ack_i=0` sampled at edge K; IDLE after K, `done=1` in cycle K+1. The next accept is possible at edge K+1.
- **Throughput floor:** 3 `ck` cycles per word with immediately responding ack. Real throughput is set by the synchronizer latency in both directions.
- **Same-cycle acceptance:** `in_valid` together with a returning-to-IDLE transition is not accepted in that same cycle. Acceptance requires state == IDLE at the sampling edge.

## Configuration
- **Macro:** `CDC_HS_TIMEOUT_EN`.
- **Defined:**
  - A phase counter clears on entry to REQ and on entry to REL, and increments each cycle in REQ or REL.
  - When the counter reaches `TIMEOUT_CYC - 1` with the exit condition still false, the FSM goes to ERR at the next edge and `err` is set.
  - `err` is sticky until released by `err_clr` in ERR.
  - If `err_clr` is asserted in a state other than ERR, `err` is already 0 and `err_clr` has no effect.
  - Counter width is `$clog2(TIMEOUT_CYC+1)`. It saturates, never wraps.
- **Undefined:** no counter and no ERR state; `err` is tied 0 and `err_clr` is ignored. The FSM waits indefinitely in REQ or REL.

## Structure
- **Shared package `cdc_hs_pkg`:**
  - State enum `hs_state_t`: IDLE=2'd0, REQ=2'd1, REL=2'd2, ERR=2'd3.
  - Default constants `HS_DW_DEF=2` and `HS_TIMEOUT_DEF=255`.
- **Sub-module `cdc_hs_wdog`:** one natural sub-module, holding the phase counter with clear/enable/expired.
  - Instantiated only under `CDC_HS_TIMEOUT_EN`.
  - Ports: `ck`, `rst`, `clr`, `en`, `expired`.
- **Top level:** FSM, data holding register and output decode.

## Test plan
- **Basic transfer:** reset, `in_data=2'b10` with `in_valid` one cycle, ack model raising `ack_i` 3 cycles after `rdy_o` and dropping it 3 cycles after `rdy_o` falls.
  - `hold_data=2'b10` throughout.
  - `rdy_o` high for 4 cycles.
  - `done` pulses once.
  - `in_ready` is high again the cycle after `done`.
- **Back-to-back words:** `in_valid` held high with words 0,1,2,3 in sequence.
  - Each word appears on `hold_data` in order, no skips or duplicates.
  - `hold_data` never changes while `busy=1`.
  - 4 `done` pulses.
- **Stale ack:** `ack_i=1` while IDLE with `in_valid=1`.
  - `in_ready=0`, no accept, `rdy_o` stays 0.
  - After `ack_i` falls, the word is accepted on the next edge.
- **Reset during REQ:** assert `rst` while `rdy_o=1`.
  - After the edge: `rdy_o=0`, `busy=0`, `hold_data=0`, no `done`.
- **Timeout, with `CDC_HS_TIMEOUT_EN` and `TIMEOUT_CYC=8`:** ack never returns.
  - ERR is entered 8 cycles after `rdy_o` rises; `err=1`, `rdy_o=0`.
  - `err_clr` releases to IDLE and `err=0` next cycle.
- **No-timeout build:** same stimulus without the macro.
  - `rdy_o` stays 1 for 1000 cycles and `err` stays 0.

Source files
------------

// File: rtl/cdc_hs_pkg.sv
// cdc_hs_pkg: shared state encoding and default sizing
// for the four-phase rdy/ack CDC sender.
package cdc_hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    ERR  = 2'd3
  } hs_state_t;

  localparam int HS_DW_DEF      = 2;
  localparam int HS_TIMEOUT_DEF = 255;

endpackage

// File: rtl/cdc_hs_wdog.sv
// cdc_hs_wdog: per-phase watchdog counter for cdc_hs_tx.
// Clear wins over enable; the count saturates instead of wrapping.
module cdc_hs_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic ck,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] TOP  = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TOP)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q >= LAST);

endmodule

// File: rtl/cdc_hs_tx.sv
// cdc_hs_tx: source-side four-phase rdy/ack CDC sender.
// Define CDC_HS_TIMEOUT_EN to add the per-phase watchdog and ERR state.
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int DW          = HS_DW_DEF,
  parameter int TIMEOUT_CYC = HS_TIMEOUT_DEF
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] hold_data,
  output logic          rdy_o,
  input  logic          ack_i,
  output logic          busy,
  output logic          done,
  output logic          err,
  input  logic          err_clr
);

  hs_state_t     state_q;
  hs_state_t     state_d;
  logic [DW-1:0] hold_q;
  logic          rdy_q;
  logic          done_q;
  logic          accept;
  logic          expired;

  assign in_ready = (state_q == IDLE) && !ack_i;
  assign accept   = in_valid && in_ready;

`ifdef CDC_HS_TIMEOUT_EN
  logic err_q;
  logic wd_clr;
  logic wd_en;

  // restart the phase timer on every entry into REQ or REL
  assign wd_clr = (state_d != state_q) &&
                  ((state_d == REQ) || (state_d == REL));
  assign wd_en  = (state_q == REQ) || (state_q == REL);

  cdc_hs_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .ck     (ck),
    .rst    (rst),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(expired)
  );

  assign err = err_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{err_clr, TIMEOUT_CYC[0]};
  assign expired    = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = REQ;
      REQ: begin
        if (ack_i) state_d = REL;
        else if (expired) state_d = ERR;
      end
      REL: begin
        if (!ack_i) state_d = IDLE;
        else if (expired) state_d = ERR;
      end
`ifdef CDC_HS_TIMEOUT_EN
      ERR: if (err_clr && !ack_i) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      // rdy is a pure flop so the crossing sees no glitches
      rdy_q   <= (state_d == REQ);
      done_q  <= (state_q == REL) && (state_d == IDLE);
      if (accept) hold_q <= in_data;
`ifdef CDC_HS_TIMEOUT_EN
      err_q   <= (state_d == ERR);
`endif
    end
  end

  assign hold_data = hold_q;
  assign rdy_o     = rdy_q;
  assign done      = done_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb_cdc_hs_tx: self-checking bench for cdc_hs_tx with a
// delayed-ack responder and a word/phase-length reference model.
module tb_cdc_hs_tx;

  localparam int DW = 2;
`ifdef CDC_HS_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic          ck = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] hold_data;
  logic          rdy_o;
  logic          ack_i = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic          err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  bit auto_ack = 1'b0;
  int dly_up = 0;
  int dly_dn = 0;
  int up_cnt = 0;
  int dn_cnt = 0;

  int            cyc = 0;
  int            done_cnt = 0;
  int            hold_viol = 0;
  int            run = 0;
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_hold = '0;
  logic [DW-1:0] got[$];
  int            runs[$];
  int            acc_cyc[$];

  always #5 ck = ~ck;

  cdc_hs_tx #(
    .DW(DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .ck       (ck),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .hold_data(hold_data),
    .rdy_o    (rdy_o),
    .ack_i    (ack_i),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_clr  (err_clr)
  );

  // one clock: observe, then let the ack model react
  task automatic tick();
    @(posedge ck);
    #1;
    cyc++;
    if (done === 1'b1) done_cnt++;
    if (busy && !prev_busy) begin
      got.push_back(hold_data);
      acc_cyc.push_back(cyc);
    end
    if (busy && prev_busy && (hold_data !== prev_hold)) hold_viol++;
    if (rdy_o === 1'b1) run++;
    else if (run > 0) begin
      runs.push_back(run);
      run = 0;
    end
    prev_busy = busy;
    prev_hold = hold_data;
    if (auto_ack) begin
      if (!ack_i) begin
        dn_cnt = 0;
        if (rdy_o) begin
          up_cnt++;
          if (up_cnt > dly_up) begin
            ack_i = 1'b1;
            up_cnt = 0;
          end
        end else up_cnt = 0;
      end else begin
        up_cnt = 0;
        if (!rdy_o) begin
          dn_cnt++;
          if (dn_cnt > dly_dn) begin
            ack_i = 1'b0;
            dn_cnt = 0;
          end
        end else dn_cnt = 0;
      end
    end
    #1;
  endtask

  task automatic clr_mon();
    got.delete();
    runs.delete();
    acc_cyc.delete();
    run = 0;
    done_cnt = 0;
    hold_viol = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    tests++;
    if ({rdy_o, busy, done, err} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctl got rdy/busy/done/err=%b want 0000",
               {rdy_o, busy, done, err});
    end
    tests++;
    if (hold_data !== '0) begin
      fails++;
      $display("FAIL reset_hold got %b want 00", hold_data);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", in_ready);
    end
    ack_i = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_ack got %b want 0", in_ready);
    end
    ack_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    clr_mon();
    auto_ack = 1'b1;
    dly_up = 3;
    dly_dn = 3;
    in_data = 2'b10;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data = 2'b01;
    for (int i = 0; i < 60 && done_cnt == 0; i++) tick();
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL basic_done got %0d want 1", done_cnt);
    end
    tests++;
    if (runs.size() != 1 || runs[0] != dly_up + 1) begin
      fails++;
      $display("FAIL basic_rdy_len got n=%0d len=%0d want len %0d",
               runs.size(), (runs.size() > 0) ? runs[0] : -1, dly_up + 1);
    end
    tests++;
    if (got.size() != 1 || hold_data !== 2'b10 || hold_viol != 0) begin
      fails++;
      $display("FAIL basic_hold got %b viol=%0d want 10 viol=0",
               hold_data, hold_viol);
    end
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_ready got %b want 1", in_ready);
    end
    tick();
    tests++;
    if (done !== 1'b0 || done_cnt != 1) begin
      fails++;
      $display("FAIL basic_pulse got done=%b cnt=%0d want 0/1",
               done, done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    bit acc;
    clr_mon();
    auto_ack = 1'b1;
    dly_up = 0;
    dly_dn = 0;
    idx = 0;
    in_data = 2'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && done_cnt < 4; i++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 4) in_data = DW'(idx);
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    tests++;
    if (done_cnt != 4) begin
      fails++;
      $display("FAIL b2b_done got %0d want 4", done_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= got.size() || got[i] !== DW'(i)) begin
        fails++;
        $display("FAIL b2b_word%0d got %b want %0d", i,
                 (i < got.size()) ? got[i] : 2'bxx, i);
      end
    end
    tests++;
    if (hold_viol != 0) begin
      fails++;
      $display("FAIL b2b_stable got %0d changes want 0", hold_viol);
    end
    tests++;
    if (acc_cyc.size() != 4 || acc_cyc[3] - acc_cyc[0] != 9) begin
      fails++;
      $display("FAIL b2b_rate got n=%0d span=%0d want 4/9", acc_cyc.size(),
               (acc_cyc.size() == 4) ? acc_cyc[3] - acc_cyc[0] : -1);
    end
  endtask

  task automatic test_stale_ack();
    auto_ack = 1'b0;
    ack_i = 1'b1;
    in_data = 2'b01;
    in_valid = 1'b1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL stale_ready got %b want 0", in_ready);
    end
    tick();
    tick();
    tick();
    tests++;
    if (rdy_o !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL stale_noacc got rdy=%b busy=%b want 0/0", rdy_o, busy);
    end
    ack_i = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL stale_release got %b want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (busy !== 1'b1 || rdy_o !== 1'b1 || hold_data !== 2'b01) begin
      fails++;
      $display("FAIL stale_accept got busy=%b rdy=%b hold=%b want 1/1/01",
               busy, rdy_o, hold_data);
    end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    tick();
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL stale_done got %b want 1", done);
    end
    tick();
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_w[$];
    int            exp_r[$];
    logic [DW-1:0] w;
    bit            acc;
    clr_mon();
    auto_ack = 1'b1;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 20 && (busy || ack_i); i++) tick();
      dly_up = int'($urandom_range(0, 5));
      dly_dn = int'($urandom_range(0, 5));
      for (int g = int'($urandom_range(0, 3)); g > 0; g--) tick();
      w = DW'($urandom);
      exp_w.push_back(w);
      exp_r.push_back(dly_up + 1);
      in_data = w;
      in_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
        acc = in_valid && in_ready;
        tick();
      end
      in_valid = 1'b0;
      in_data = DW'($urandom);
      for (int i = 0; i < 60 && done_cnt < n + 1; i++) tick();
    end
    tests++;
    if (done_cnt != exp_w.size()) begin
      fails++;
      $display("FAIL rnd_done got %0d want %0d", done_cnt, exp_w.size());
    end
    tests++;
    if (got.size() != exp_w.size() || runs.size() != exp_r.size()) begin
      fails++;
      $display("FAIL rnd_count got words=%0d runs=%0d want %0d",
               got.size(), runs.size(), exp_w.size());
    end
    for (int i = 0; i < exp_w.size() && i < got.size()
                    && i < runs.size(); i++) begin
      tests++;
      if (got[i] !== exp_w[i] || runs[i] != exp_r[i]) begin
        fails++;
        $display("FAIL rnd_xfer%0d got w=%b len=%0d want w=%b len=%0d",
                 i, got[i], runs[i], exp_w[i], exp_r[i]);
      end
    end
    tests++;
    if (hold_viol != 0) begin
      fails++;
      $display("FAIL rnd_stable got %0d changes want 0", hold_viol);
    end
  endtask

  task automatic test_reset_req();
    clr_mon();
    auto_ack = 1'b0;
    ack_i = 1'b0;
    in_data = 2'b11;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (rdy_o !== 1'b1) begin
      fails++;
      $display("FAIL rstreq_pre got rdy=%b want 1", rdy_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({rdy_o, busy, done} !== 3'b000 || hold_data !== '0) begin
      fails++;
      $display("FAIL rstreq_abort got rdy/busy/done=%b hold=%b want 000/00",
               {rdy_o, busy, done}, hold_data);
    end
    tick();
    tests++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstreq_nodone got cnt=%0d busy=%b want 0/0",
               done_cnt, busy);
    end
  endtask

`ifdef CDC_HS_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    auto_ack = 1'b0;
    ack_i = 1'b0;
    in_data = 2'b01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (err !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    tests++;
    if (k != TO) begin
      fails++;
      $display("FAIL to_latency got %0d want %0d", k, TO);
    end
    tests++;
    if ({rdy_o, in_ready, busy} !== 3'b001) begin
      fails++;
      $display("FAIL to_err_state got rdy/ready/busy=%b want 001",
               {rdy_o, in_ready, busy});
    end
    ack_i = 1'b1;
    err_clr = 1'b1;
    tick();
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL to_clr_blocked got err=%b want 1", err);
    end
    ack_i = 1'b0;
    tick();
    err_clr = 1'b0;
    tests++;
    if (err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL to_release got err/busy/ready=%b want 001",
               {err, busy, in_ready});
    end
  endtask
`else
  task automatic test_no_timeout();
    int bad;
    clr_mon();
    auto_ack = 1'b0;
    ack_i = 1'b0;
    in_data = 2'b01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (rdy_o !== 1'b1 || err !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL nto_hold got %0d bad cycles want 0", bad);
    end
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    tick();
    tests++;
    if (done !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL nto_finish got done=%b err=%b want 1/0", done, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stale_ack();
    test_random();
    test_reset_req();
`ifdef CDC_HS_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
